truth_table_reader: RTL and testbench
=====================================

# truth_table_reader

Sequential characterization engine for the synthesized 4-input logic gates in our design set. It drives every input combination into a combinational gate netlist and waits a programmable settle time per row. It then samples the gate output and assembles the measured truth table in our hex naming convention (e.g. 0x0239). The measured table is compared against an expected value. The block sits on the bench/FPGA side, at the other end of the gate's input/output pins: the gate computes a function from its inputs, and this block reads the function back out.

## Interface
- `N_IN`, 4: number of gate inputs. ROWS = 2**N_IN.
- `SETTLE`, 2: extra wait cycles per row before sampling, ≥0.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a sweep; honoured only in IDLE.
- `expected` in ROWS: expected truth table; latched on accepted `start`.
- `stim` out N_IN: gate input vector. `stim[N_IN-1]` drives gate input `_0`, down to `stim[0]` driving `_3`. Registered.
- `dut_out` in 1: gate output, sampled at the end of each row.
- `busy` out 1: sweep in progress.
- `done` out 1: one-cycle pulse when the result is valid.
- `table_out` out ROWS: measured truth table; held until the next accepted `start`.
- `match` out 1: `table_out == expected`; valid from `done` onward and held.
- `mismatch_cnt` out clog2(ROWS)+1: number of differing rows.
- `first_bad` out clog2(ROWS): lowest row index that mismatched; 0 if none.

## Operation
- Row n drives `stim = n`. The measured output of row n is stored at `table_out[ROWS-1-n]`, so row 0 is the MSB, which matches the hex naming convention.
- FSM states:
  - IDLE: `busy`=0 and `stim`=0. On `start`, the block latches `expected`, clears `table_out`, `mismatch_cnt` and `first_bad`, sets row=0 and wait count=0, and moves to RUN.
  - RUN: `busy`=1 and `stim`=row. The wait counter increments every cycle.
    - When the counter equals SETTLE, the block samples `dut_out` into bit ROWS-1-row.
    - If the sample differs from `expected[ROWS-1-row]`: `mismatch_cnt` increments, and if this is the first mismatch, `first_bad` is set to row.
    - If row == ROWS-1, the FSM moves to DONE. Otherwise row increments and the counter clears.
  - DONE: `done`=1 and `busy`=0 for one cycle. `match` = (`mismatch_cnt`==0). The FSM then returns to IDLE.
- Row counter width is N_IN. Row ROWS-1 is terminal, so the counter never wraps.
- `start` while in RUN or DONE is ignored and has no queueing effect. `expected` changes during RUN are ignored because the value was latched at start.
- `rst` at any cycle, including mid-sweep: the next state is IDLE, and all outputs go to their reset values. A partial table is discarded.
- Reset values: `stim`=0, `busy`=0, `done`=0, `table_out`=0, `match`=0, `mismatch_cnt`=0, `first_bad`=0.

## Timing
- Edge t0 is the edge that accepts `start`. From cycle t0+1, `busy`=1 and `stim`=0.
- Row n is driven for SETTLE+1 cycles, starting at cycle t0+1+n·(SETTLE+1). It is sampled on the last edge of that window.
- `dut_out` must be valid within SETTLE+1 cycles of a `stim` change; the gate path is purely combinational.
- `done` is high in cycle t0+1+ROWS·(SETTLE+1). With defaults that is t0+49; with SETTLE=0 it is t0+17.
- `table_out`, `match`, `mismatch_cnt` and `first_bad` are stable from the `done` cycle until the next accepted start.
- Back-to-back operation: `start` high in the cycle after `done` (the IDLE cycle) is accepted. `start` is never accepted in the `done` cycle itself.

## Test plan
- Golden gate. Connect a behavioural model f = (a|c)&((b&~d)^(a&c)), with a=`stim[3]`, b=`stim[2]`, c=`stim[1]`, d=`stim[0]`. Set `expected`=16'h0239 and use defaults.
  - Required: `table_out`=16'h0239, `match`=1, `mismatch_cnt`=0, `first_bad`=0, `done` exactly at t0+49.
- Same golden gate with `expected`=16'h0238.
  - Required: `match`=0, `mismatch_cnt`=1, `first_bad`=15.
- `dut_out` stuck at 0 with `expected`=16'h0239.
  - Required: `table_out`=0, `mismatch_cnt`=5, `first_bad`=6 (rows 6, 10, 11, 12, 15 mismatch).
- SETTLE=0 with the golden gate.
  - Required: `done` at t0+17, `table_out`=16'h0239. `stim` must step 0..15 with one cycle per row.
- `start` pulsed again at t0+10, and `expected` changed mid-sweep.
  - Required: no restart and result unchanged, with `done` at t0+49. A `start` in the cycle after `done` begins a new sweep.
- `rst` asserted while `stim`=7.
  - Required: next cycle `stim`=0, `busy`=0, `table_out`=0, and no `done` pulse. A fresh `start` then yields 16'h0239.

Source files
------------

// File: rtl/truth_table_reader.sv
// truth_table_reader: sweeps every input row of an N_IN-input gate, samples its output after
// SETTLE extra cycles and assembles the measured truth table (row 0 in the MSB).
module truth_table_reader #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [(1<<N_IN)-1:0]  expected,
    output logic [N_IN-1:0]       stim,
    input  logic                  dut_out,
    output logic                  busy,
    output logic                  done,
    output logic [(1<<N_IN)-1:0]  table_out,
    output logic                  match,
    output logic [N_IN:0]         mismatch_cnt,
    output logic [N_IN-1:0]       first_bad
);

    localparam int ROWS   = 1 << N_IN;
    localparam int WAIT_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    localparam logic [WAIT_W-1:0] SETTLE_C = WAIT_W'(SETTLE);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
    localparam logic [N_IN-1:0]   ROW_ONE  = N_IN'(1);
    localparam logic [N_IN-1:0]   ROW_LAST = {N_IN{1'b1}};
    localparam logic [N_IN:0]     CNT_ONE  = (N_IN + 1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [N_IN-1:0]     row_q, row_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [ROWS-1:0]     exp_q, exp_d;
    logic [ROWS-1:0]     tbl_q, tbl_d;
    logic [N_IN:0]       mis_q, mis_d;
    logic [N_IN-1:0]     fb_q, fb_d;
    logic                match_q, match_d;
    logic [N_IN-1:0]     bit_idx;

    // Row n lands at bit ROWS-1-n, which is the bitwise complement of n.
    assign bit_idx = ~row_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            wait_q  <= '0;
            exp_q   <= '0;
            tbl_q   <= '0;
            mis_q   <= '0;
            fb_q    <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            wait_q  <= wait_d;
            exp_q   <= exp_d;
            tbl_q   <= tbl_d;
            mis_q   <= mis_d;
            fb_q    <= fb_d;
            match_q <= match_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        wait_d  = wait_q;
        exp_d   = exp_q;
        tbl_d   = tbl_q;
        mis_d   = mis_q;
        fb_d    = fb_q;
        match_d = match_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    exp_d   = expected;
                    tbl_d   = '0;
                    mis_d   = '0;
                    fb_d    = '0;
                    match_d = 1'b0;
                    row_d   = '0;
                    wait_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                wait_d = wait_q + WAIT_ONE;
                if (wait_q == SETTLE_C) begin
                    tbl_d[bit_idx] = dut_out;
                    if (dut_out != exp_q[bit_idx]) begin
                        mis_d = mis_q + CNT_ONE;
                        if (mis_q == '0) begin
                            fb_d = row_q;
                        end
                    end
                    wait_d = '0;
                    if (row_q == ROW_LAST) begin
                        // Row returns to 0 so stim is already idle-valued in DONE.
                        row_d   = '0;
                        match_d = (mis_d == '0);
                        state_d = DONE;
                    end else begin
                        row_d = row_q + ROW_ONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign stim         = row_q;
    assign busy         = (state_q == RUN);
    assign done         = (state_q == DONE);
    assign table_out    = tbl_q;
    assign match        = match_q;
    assign mismatch_cnt = mis_q;
    assign first_bad    = fb_q;

endmodule

// File: tb/tb_truth_table_reader.sv
// Directed bench for truth_table_reader: a behavioural gate drives two instances (SETTLE=2 and
// SETTLE=0); expected results are queued at start and compared when done pulses.
module tb_truth_table_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, start1;
    logic [15:0] exp0, exp1;
    logic        stuck0;
    logic        dout0, dout1;
    logic [3:0]  stim0, stim1, fb0, fb1;
    logic        busy0, busy1, done0, done1, match0, match1;
    logic [15:0] tbl0, tbl1;
    logic [4:0]  mis0, mis1;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    int base   = 0;

    typedef struct {
        logic [15:0] tbl;
        logic        m;
        logic [4:0]  cnt;
        logic [3:0]  fb;
        int          lat;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic gate_f(input logic [3:0] s);
        logic a, b, c, d;
        a = s[3];
        b = s[2];
        c = s[1];
        d = s[0];
        return (a | c) & ((b & ~d) ^ (a & c));
    endfunction

    assign dout0 = stuck0 ? 1'b0 : gate_f(stim0);
    assign dout1 = gate_f(stim1);

    truth_table_reader #(.N_IN(4), .SETTLE(2)) u0 (
        .clk(clk), .rst(rst), .start(start0), .expected(exp0), .stim(stim0),
        .dut_out(dout0), .busy(busy0), .done(done0), .table_out(tbl0),
        .match(match0), .mismatch_cnt(mis0), .first_bad(fb0)
    );

    truth_table_reader #(.N_IN(4), .SETTLE(0)) u1 (
        .clk(clk), .rst(rst), .start(start1), .expected(exp1), .stim(stim1),
        .dut_out(dout1), .busy(busy1), .done(done1), .table_out(tbl1),
        .match(match1), .mismatch_cnt(mis1), .first_bad(fb1)
    );

    function automatic exp_t model(input logic [15:0] e, input logic stuck, input int settle);
        exp_t x;
        logic b;
        x.tbl = '0;
        x.cnt = '0;
        x.fb  = '0;
        for (int r = 0; r < 16; r++) begin
            b = stuck ? 1'b0 : gate_f(4'(r));
            x.tbl[15-r] = b;
            if (b != e[15-r]) begin
                if (x.cnt == 5'd0) x.fb = 4'(r);
                x.cnt = x.cnt + 5'd1;
            end
        end
        x.m   = (x.cnt == 5'd0);
        x.lat = 16 * (settle + 1);
        return x;
    endfunction

    // sel: 0 table, 1 match, 2 mismatch_cnt, 3 first_bad, 4 stim, 5 busy, 6 done
    function automatic logic [31:0] obs(input int w, input int sel);
        logic [31:0] r;
        r = '0;
        case (sel)
            0: r = (w == 0) ? 32'(tbl0)   : 32'(tbl1);
            1: r = (w == 0) ? 32'(match0) : 32'(match1);
            2: r = (w == 0) ? 32'(mis0)   : 32'(mis1);
            3: r = (w == 0) ? 32'(fb0)    : 32'(fb1);
            4: r = (w == 0) ? 32'(stim0)  : 32'(stim1);
            5: r = (w == 0) ? 32'(busy0)  : 32'(busy1);
            6: r = (w == 0) ? 32'(done0)  : 32'(done1);
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic start_sweep(input int w, input logic [15:0] e, input logic stuck);
        @(negedge clk);
        if (w == 0) begin
            exp0   = e;
            stuck0 = stuck;
            start0 = 1'b1;
            sb0.push_back(model(e, stuck, 2));
        end else begin
            exp1   = e;
            start1 = 1'b1;
            sb1.push_back(model(e, 1'b0, 0));
        end
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        base   = cyc;
        chk("busy_t0p1", obs(w, 5), 32'd1);
        chk("stim_t0p1", obs(w, 4), 32'd0);
    endtask

    task automatic wait_done(input int w, input int settle);
        exp_t x;
        int   k;
        k = 0;
        while (obs(w, 6) == 32'd0 && k < 200) begin
            chk("stim_step", obs(w, 4), 32'((cyc - base) / (settle + 1)));
            @(negedge clk);
            k++;
        end
        chk("done_seen", obs(w, 6), 32'd1);
        if (obs(w, 6) == 32'd1) begin
            chk("sb_depth", (w == 0) ? 32'(sb0.size()) : 32'(sb1.size()), 32'd1);
            if ((w == 0 && sb0.size() > 0) || (w == 1 && sb1.size() > 0)) begin
                x = (w == 0) ? sb0.pop_front() : sb1.pop_front();
                chk("table",   obs(w, 0), 32'(x.tbl));
                chk("match",   obs(w, 1), 32'(x.m));
                chk("mis_cnt", obs(w, 2), 32'(x.cnt));
                chk("first_bad", obs(w, 3), 32'(x.fb));
                chk("done_latency", 32'(cyc - base), 32'(x.lat));
                chk("busy_at_done", obs(w, 5), 32'd0);
            end
        end
    endtask

    initial begin
        int k;
        int dn;
        rst    = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        exp0   = '0;
        exp1   = '0;
        stuck0 = 1'b0;
        repeat (2) @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            for (int s = 0; s < 7; s++) begin
                chk($sformatf("reset_u%0d_sel%0d", w, s), obs(w, s), 32'd0);
            end
        end
        rst = 1'b0;

        // Golden gate, default settle
        start_sweep(0, 16'h0239, 1'b0);
        wait_done(0, 2);
        chk("golden_tbl", obs(0, 0), 32'h0239);
        chk("golden_match", obs(0, 1), 32'd1);
        @(negedge clk);
        chk("done_one_cycle", obs(0, 6), 32'd0);
        chk("tbl_held", obs(0, 0), 32'h0239);
        chk("match_held", obs(0, 1), 32'd1);

        // Single-row mismatch
        start_sweep(0, 16'h0238, 1'b0);
        wait_done(0, 2);
        chk("m1_cnt", obs(0, 2), 32'd1);
        chk("m1_fb", obs(0, 3), 32'd15);
        chk("m1_match", obs(0, 1), 32'd0);

        // Output stuck at 0
        start_sweep(0, 16'h0239, 1'b1);
        wait_done(0, 2);
        chk("stuck_tbl", obs(0, 0), 32'h0);
        chk("stuck_cnt", obs(0, 2), 32'd5);
        chk("stuck_fb", obs(0, 3), 32'd6);
        stuck0 = 1'b0;

        // SETTLE=0 instance
        start_sweep(1, 16'h0239, 1'b0);
        wait_done(1, 0);
        chk("s0_tbl", obs(1, 0), 32'h0239);

        // Restart attempt and expected change mid-sweep, then back-to-back start
        start_sweep(0, 16'h0239, 1'b0);
        repeat (9) @(negedge clk);
        start0 = 1'b1;
        exp0   = 16'hFFFF;
        @(negedge clk);
        start0 = 1'b0;
        wait_done(0, 2);
        chk("ignore_start_tbl", obs(0, 0), 32'h0239);
        start_sweep(0, 16'h0239, 1'b0);
        wait_done(0, 2);
        chk("b2b_tbl", obs(0, 0), 32'h0239);

        // Reset mid-sweep
        start_sweep(0, 16'h0239, 1'b0);
        k = 0;
        while (stim0 != 4'd7 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("reach_stim7", obs(0, 4), 32'd7);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_stim", obs(0, 4), 32'd0);
        chk("rst_busy", obs(0, 5), 32'd0);
        chk("rst_tbl", obs(0, 0), 32'd0);
        chk("rst_done", obs(0, 6), 32'd0);
        rst = 1'b0;
        sb0.delete();
        dn = 0;
        repeat (60) begin
            @(negedge clk);
            if (done0) dn++;
        end
        chk("no_done_after_rst", 32'(dn), 32'd0);
        start_sweep(0, 16'h0239, 1'b0);
        wait_done(0, 2);
        chk("post_rst_tbl", obs(0, 0), 32'h0239);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
